// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and constants for the matrix-multiply feed path
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } feed_state_t;

    localparam int STALL_CNT_W = 16;

    // Zero shifts needed for the last skewed element to reach and cross an N x N array
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: clears the input-skew crossbar, streams K vectors, then drains; FEED_STALL_CNT_EN adds a stall counter
module systolic_feed_ctrl
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int ARRAY_ELLEMENTS = 4,
    parameter int K_WIDTH         = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    input  logic [K_WIDTH-1:0]                    k_len,
    input  logic                                  src_valid,
    input  logic [ARRAY_ELLEMENTS*DATA_WIDTH-1:0] src_data,
    output logic                                  src_ready,
    output logic                                  xbar_sync_reset_n,
    output logic                                  xbar_shift,
    output logic [ARRAY_ELLEMENTS*DATA_WIDTH-1:0] xbar_data,
    output logic                                  busy,
    output logic                                  done,
    output logic [STALL_CNT_W-1:0]                stall_cnt
);

    localparam int DRN = drain_cycles(ARRAY_ELLEMENTS);
    localparam int DCW = $clog2(DRN + 1);

    feed_state_t        state, state_n;
    logic [K_WIDTH-1:0] k_rem;
    logic [DCW-1:0]     drain_cnt;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next state and crossbar/source handshake outputs
    always_comb begin
        state_n           = state;
        src_ready         = 1'b0;
        xbar_shift        = 1'b0;
        xbar_data         = '0;
        xbar_sync_reset_n = 1'b1;
        case (state)
            IDLE:  state_n = start ? CLEAR : IDLE;
            CLEAR: begin
                xbar_sync_reset_n = 1'b0;
                state_n           = (k_rem == '0) ? DONE : FEED;
            end
            FEED: begin
                src_ready  = 1'b1;
                xbar_shift = src_valid;
                xbar_data  = src_valid ? src_data : '0;
                state_n    = (src_valid && k_rem == K_WIDTH'(1)) ? DRAIN : FEED;
            end
            DRAIN: begin
                xbar_shift = 1'b1;
                state_n    = (drain_cnt == DCW'(DRN - 1)) ? DONE : DRAIN;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign busy = state != IDLE;
    assign done = state == DONE;

    // Remaining-vector and drain counters; k_rem only decrements while nonzero so it cannot wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_rem     <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && start)        k_rem <= k_len;
            else if (state == FEED && src_valid) k_rem <= k_rem - 1'b1;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

`ifdef FEED_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Saturating count of FEED cycles with no source data; cleared when a pass is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                          stall_q <= '0;
        else if (state == IDLE && start)                       stall_q <= '0;
        else if (state == FEED && !src_valid && stall_q != '1) stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: table-driven and randomized checks of systolic_feed_ctrl against a cycle-trace model
module tb_systolic_feed_ctrl;

    localparam int DW  = 8;
    localparam int N   = 4;
    localparam int KW  = 8;
    localparam int LW  = N * DW;
    localparam int DRN = 2 * N - 1;
`ifdef FEED_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          src_valid;
    logic [LW-1:0] src_data;
    logic          src_ready;
    logic          xbar_sync_reset_n;
    logic          xbar_shift;
    logic [LW-1:0] xbar_data;
    logic          busy;
    logic          done;
    logic [15:0]   stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          k;
        logic [31:0] pat;
        int          plen;
        int          exp_len;
        int          exp_stalls;
    } vec_t;

    vec_t tbl[5];

    systolic_feed_ctrl #(
        .DATA_WIDTH(DW),
        .ARRAY_ELLEMENTS(N),
        .K_WIDTH(KW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .k_len(k_len),
        .src_valid(src_valid),
        .src_data(src_data),
        .src_ready(src_ready),
        .xbar_sync_reset_n(xbar_sync_reset_n),
        .xbar_shift(xbar_shift),
        .xbar_data(xbar_data),
        .busy(busy),
        .done(done),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs one pass from IDLE (called at posedge+1); the model walks clear -> K consumed vectors -> drain -> done
    task automatic run_pass(input int k, input logic [31:0] pat, input int plen, input bit rnd,
                            input bit poke, input int exp_len, input int exp_stalls);
        int c, got, drained, stalls, hs, dut_len, pi, st;
        bit v, clr, fd, dr, dn;
        logic [LW-1:0] exp_d;
        got = 0; drained = 0; stalls = 0; hs = 0; dut_len = 0; pi = 0; c = 1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        k_len = KW'($urandom);
        forever begin
            clr = c == 1;
            fd  = !clr && got < k;
            dr  = !clr && !fd && k != 0 && drained < DRN;
            dn  = !clr && !fd && !dr;
            v   = fd ? (rnd ? ($urandom_range(0, 3) != 0) : (pi < plen ? pat[pi] : 1'b1))
                     : 1'($urandom_range(0, 1));
            if (fd) pi++;
            src_valid = v;
            src_data  = LW'($urandom);
            start     = poke && fd && got == 0;
            if (start) k_len = KW'(9);
            @(negedge clk);
            exp_d = (fd && v) ? src_data : '0;
            check("cycle", 64'({src_ready, xbar_shift, xbar_sync_reset_n, busy, done, xbar_data}),
                  64'({fd, (fd && v) || dr, !clr, 1'b1, dn, exp_d}));
            if (src_ready && xbar_shift) hs++;
            if (done && dut_len == 0) dut_len = c;
            got     += int'(fd && v);
            stalls  += int'(fd && !v);
            drained += int'(dr);
            @(posedge clk); #1;
            if (dn) break;
            if (c >= 1000) begin
                check("pass_timeout", 64'(c), 64'(0));
                break;
            end
            c++;
        end
        start     = 1'b0;
        src_valid = 1'b0;
        st = STALL_EN ? (exp_stalls < 0 ? stalls : exp_stalls) : 0;
        check("idle_after", 64'({busy, done, src_ready, xbar_shift, xbar_sync_reset_n}), 64'(5'b00001));
        check("pass_len", 64'(dut_len), 64'(exp_len < 0 ? c : exp_len));
        check("handshakes", 64'(hs), 64'(k));
        check("stall_cnt", 64'(stall_cnt), 64'(st));
        @(posedge clk); #1;
        check("stall_hold", 64'(stall_cnt), 64'(st));
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        src_valid = 1'b0;
        src_data  = '0;

        tbl[0] = '{3, 32'h0,  0, 12, 0};
        tbl[1] = '{4, 32'h59, 7, 16, 3};
        tbl[2] = '{0, 32'h0,  0, 2,  0};
        tbl[3] = '{1, 32'h4,  3, 12, 2};
        tbl[4] = '{2, 32'h0,  0, 11, 0};

        #12;
        check("rst_ctl", 64'({src_ready, xbar_sync_reset_n, xbar_shift, busy, done}), 64'(5'b01000));
        check("rst_data", 64'(xbar_data), 64'(0));
        check("rst_stall", 64'(stall_cnt), 64'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++)
            run_pass(tbl[i].k, tbl[i].pat, tbl[i].plen, 1'b0, 1'b0, tbl[i].exp_len, tbl[i].exp_stalls);

        run_pass(3, 32'h0, 0, 1'b0, 1'b1, 12, 0);

        start     = 1'b1;
        k_len     = KW'(2);
        src_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drain_shift", 64'({busy, xbar_shift, src_ready}), 64'(3'b110));
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_ctl", 64'({src_ready, xbar_sync_reset_n, xbar_shift, busy, done}), 64'(5'b01000));
        check("rst_mid_data", 64'(xbar_data), 64'(0));
        check("rst_mid_stall", 64'(stall_cnt), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold", 64'({busy, done, xbar_shift}), 64'(0));
        end
        @(posedge clk); #1;
        reset_n   = 1'b1;
        src_valid = 1'b0;
        @(posedge clk); #1;
        run_pass(3, 32'h0, 0, 1'b0, 1'b0, 12, 0);

        run_pass(255, 32'h0, 0, 1'b0, 1'b0, 1 + 255 + DRN + 1, 0);

        for (int i = 0; i < 6; i++)
            run_pass($urandom_range(0, 20), 32'h0, 0, 1'b1, i == 3, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
